ex_div_seq: RTL and testbench
=============================

# ex_div_seq

Iterative 32-bit divider sequencer for the EX stage, serving MIPS DIV/DIVU. It accepts one division request from EX, runs a 32-iteration restoring division, and produces the {HI, LO} result. While the operation is in flight, it drives the EX-stage stall request into the stall controller, which freezes PC, IF and ID.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  EX holds a DIV/DIVU. Stays high until the cycle o_ready is seen.
- i_signed  in  1  1 = DIV (signed), 0 = DIVU. Sampled with the operands.
- i_dividend  in  WIDTH  rs value. Sampled on acceptance.
- i_divisor  in  WIDTH  rt value. Sampled on acceptance.
- i_annul  in  1  cancel the current operation (flush/exception). Overrides i_start.
- o_result  out  2*WIDTH  {remainder (HI), quotient (LO)}.
- o_ready  out  1  result valid.
- o_stallreq  out  1  stall request to the stall controller's EX input.

## Operation
- States: IDLE, BUSY, DIVZERO, DONE. Reset state is IDLE.
- IDLE:
  - i_start=1 and i_annul=0 → accept: capture i_signed, the operand signs, |dividend|, |divisor|, clear counter.
  - If divisor==0 go to DIVZERO, else go to BUSY.
  - Absolute value is taken only when i_signed=1. |0x80000000| = 0x80000000, treated as unsigned 2^31.
- BUSY, one restoring step per cycle, with R = 33-bit partial remainder, Q = shifting dividend/quotient, D = divisor:
  - R' = {R[31:0], Q[31]}.
  - If R' ≥ D: R = R' − D, Q = {Q[30:0], 1}.
  - Else: R = R', Q = {Q[30:0], 0}.
  - Counter is 5 bits and increments each step. The step taken with counter==31 moves to DONE.
- DIVZERO: one cycle, then DONE with quotient=0 and remainder=0 (MIPS leaves the result undefined; we fix it to 0).
- Result registration, on the transition into DONE:
  - Unsigned: o_result = {R[31:0], Q}.
  - Signed: quotient is negated if the dividend and divisor signs differ; remainder takes the dividend's sign. All arithmetic is mod 2^32.
- DONE:
  - o_ready=1.
  - Stay in DONE while i_start=1 and i_annul=0.
  - On i_start=0 or i_annul=1, go to IDLE the next cycle.
- o_result holds its value outside DONE until the next DONE entry. Reset value is 0.
- o_ready = (state==DONE). Registered; 0 in reset.
- o_stallreq = i_start & ~i_annul & (state != DONE). Combinational; during reset it equals i_start & ~i_annul.
- i_annul=1 in BUSY or DIVZERO → IDLE next cycle; partial results are discarded and o_result is unchanged. i_annul=1 in IDLE → no acceptance.
- Reset asserted mid-operation: immediate IDLE, o_ready=0, o_result=0, counter=0.
- Back-to-back: a new request is accepted only from IDLE, so i_start must drop for at least one cycle between operations. EX does this naturally when the next instruction arrives.

## Timing
- Normal accept in cycle N:
  - BUSY in cycles N+1..N+32.
  - DONE and o_ready=1 in cycle N+33.
  - o_stallreq=1 in cycles N..N+32 (33 cycles); it drops in N+33 as DONE is reached.
- Divisor zero: DIVZERO in N+1; DONE and o_ready in N+2; o_stallreq=1 in cycles N..N+1.
- i_annul raised in cycle M: o_stallreq=0 in M (combinational); state=IDLE in M+1.
- i_start low in a DONE cycle: IDLE the following cycle.
- No combinational path from operands to outputs; the only combinational path is from i_start/i_annul to o_stallreq.

## Test plan
- DIVU 100 / 7 → o_result = {32'd2, 32'd14}; o_ready first high 33 cycles after accept; o_stallreq high for exactly 33 cycles.
- DIV −7 / 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Corner operands:
  - DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
  - DIVU 5 / 9 → quotient 0, remainder 5.
- Divide by zero (DIVU 1234 / 0) → o_ready in cycle N+2; o_result = 0; o_stallreq high for 2 cycles.
- Annul in cycle N+10:
  - o_stallreq low the same cycle; IDLE in N+11; o_result keeps its previous value.
  - A new DIVU 9 / 3 issued afterwards → {0, 3} after 33 cycles.
- Reset mid-BUSY (i_rst_n low in cycle N+5, asynchronously) → o_ready=0 and o_result=0 immediately. After release, DIVU 100 / 7 completes normally.

Source files
------------

// File: rtl/ex_div_seq.sv
// rtl/ex_div_seq.sv - iterative 32-bit restoring divider sequencer for EX-stage DIV/DIVU
//
// Accepts one division from EX, runs WIDTH restoring steps (one per cycle),
// and registers {HI, LO} = {remainder, quotient} on entry to DONE.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      EX holds a DIV/DIVU; held until o_ready is seen
//   i_signed     1 = DIV (signed), 0 = DIVU
//   i_dividend   rs operand, sampled on acceptance
//   i_divisor    rt operand, sampled on acceptance
//   i_annul      cancel the current operation; overrides i_start
//   o_result     {remainder (HI), quotient (LO)}
//   o_ready      result valid (state == DONE)
//   o_stallreq   stall request to the stall controller's EX input

module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    input  logic                 i_annul,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_ready,
    output logic                 o_stallreq
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DIVZERO = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic             sgn_q;
    logic             dvd_neg_q;
    logic             dvs_neg_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] result_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic             r_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    assign accept    = (state == IDLE) && i_start && !i_annul;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // Magnitudes; 0x80000000 maps to itself and is read as unsigned 2^31.
    assign dvd_abs = (i_signed && i_dividend[WIDTH-1]) ? (~i_dividend + 1'b1) : i_dividend;
    assign dvs_abs = (i_signed && i_divisor[WIDTH-1])  ? (~i_divisor + 1'b1)  : i_divisor;

    // One restoring step. The partial remainder is always below D, so the
    // shifted value is below 2*D and the borrow bit alone decides R' >= D.
    assign r_shift  = {rem_q, quo_q[WIDTH-1]};
    assign r_sub    = r_shift - {1'b0, dvs_q};
    assign r_ge     = ~r_sub[WIDTH];
    assign rem_next = r_ge ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], r_ge};

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
    assign quo_fin = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (~quo_next + 1'b1) : quo_next;
    assign rem_fin = (sgn_q && dvd_neg_q) ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (i_divisor == '0) ? DIVZERO : BUSY;
                end
            end
            BUSY: begin
                if (i_annul) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DIVZERO: begin
                state_next = i_annul ? IDLE : DONE;
            end
            DONE: begin
                if (!i_start || i_annul) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn_q     <= i_signed;
                        dvd_neg_q <= i_signed & i_dividend[WIDTH-1];
                        dvs_neg_q <= i_signed & i_divisor[WIDTH-1];
                        rem_q     <= '0;
                        quo_q     <= dvd_abs;
                        dvs_q     <= dvs_abs;
                        cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (!i_annul) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            result_q <= {rem_fin, quo_fin};
                        end
                    end
                end
                DIVZERO: begin
                    // Architecturally undefined; pinned to zero.
                    if (!i_annul) begin
                        result_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result   = result_q;
    assign o_ready    = (state == DONE);
    assign o_stallreq = i_start & ~i_annul & (state != DONE);

endmodule

// File: tb/tb_ex_div_seq.sv
// tb/tb_ex_div_seq.sv - scoreboard testbench for ex_div_seq

module tb_ex_div_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        i_annul = 1'b0;
    logic [63:0] o_result;
    logic        o_ready;
    logic        o_stallreq;

    ex_div_seq #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_annul    (i_annul),
        .o_result   (o_result),
        .o_ready    (o_ready),
        .o_stallreq (o_stallreq)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising o_ready is matched against the oldest expectation.
    logic rdy_prev = 1'b0;
    always @(negedge i_clk) begin
        if (i_rst_n && o_ready && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                chk("result", o_result, exp_q.pop_front());
                chk("ready_latency", 64'(cyc - acc_q.pop_front()), 64'(lat_q.pop_front()));
            end
        end
        rdy_prev = i_rst_n & o_ready;
    end

    // Drive a request in the current cycle and record its expectation.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
        i_signed   = sg;
        i_dividend = a;
        i_divisor  = b;
        i_annul    = 1'b0;
        i_start    = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        acc_q.push_back(cyc);
    endtask

    // Wait for o_ready, counting stall cycles, then retire the request.
    task automatic finish(input logic [63:0] exp, input int lat);
        int  stalls = 0;
        bit  got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge i_clk);
            if (o_ready) got = 1;
            else if (o_stallreq) stalls++;
        end
        chk("ready_seen", 64'(got), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'(lat));
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("ready_hold_in_done", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        chk("ready_drop_after_start_low", 64'(o_ready), 64'd0);
        chk("result_held_idle", o_result, exp);
    endtask

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat);
        @(posedge i_clk); #1;
        issue(sg, a, b, exp, lat);
        finish(exp, lat);
    endtask

    initial begin
        // Reset state, including the combinational stall path.
        i_start = 1'b1;
        #2;
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_result", o_result, 64'd0);
        chk("rst_stall_start", 64'(o_stallreq), 64'd1);
        i_annul = 1'b1;
        #1;
        chk("rst_stall_annul", 64'(o_stallreq), 64'd0);
        i_start = 1'b0;
        i_annul = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        run_div(1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},        33);
        run_div(1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div(1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0000}, 33);
        run_div(1'b0, 32'hFFFF_FFFF,  32'h1,          {32'h0,         32'hFFFF_FFFF}, 33);
        run_div(1'b0, 32'd5,          32'd9,          {32'd5,         32'd0},         33);
        run_div(1'b0, 32'd1234,       32'd0,          64'd0,                          2);
        run_div(1'b0, 32'd5,          32'd9,          {32'd5,         32'd0},         33);

        // Annul in cycle N+10 of a DIVU 0xFFFF/3; prior result is {5,0}.
        @(posedge i_clk); #1;
        i_signed = 1'b0; i_dividend = 32'hFFFF; i_divisor = 32'd3; i_start = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        i_annul = 1'b1;
        @(negedge i_clk);
        chk("annul_stall_low", 64'(o_stallreq), 64'd0);
        chk("annul_result_kept", o_result, {32'd5, 32'd0});
        @(posedge i_clk); #1;
        chk("annul_ready_low", 64'(o_ready), 64'd0);
        chk("annul_result_kept2", o_result, {32'd5, 32'd0});
        // Immediate acceptance here only happens if the FSM is back in IDLE.
        issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        finish({32'd0, 32'd3}, 33);

        // Asynchronous reset in cycle N+5 of a DIVU 100/7; prior result is {0,3}.
        @(posedge i_clk); #1;
        i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
        repeat (5) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(o_ready), 64'd0);
        chk("midrst_result", o_result, 64'd0);
        chk("midrst_stall", 64'(o_stallreq), 64'd1);
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        repeat (3) @(posedge i_clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
